// File: rtl/seg7_frame_scheduler_pkg.sv
// Shared definitions for the seven-segment display path: source encodings,
// frame geometry and the hex segment table used by the shift engine too.
package seg7_pkg;

   localparam int FRAME_W = 64;
   localparam int DIGITS  = 8;

   typedef enum logic [1:0] {
      ST_SPEC  = 2'd0,
      ST_MSG   = 2'd1,
      ST_ALARM = 2'd2
   } sched_state_t;

   localparam logic [1:0] SRC_SPEC  = 2'd0;
   localparam logic [1:0] SRC_MSG   = 2'd1;
   localparam logic [1:0] SRC_ALARM = 2'd2;

   localparam logic [FRAME_W-1:0] FRAME_BLANK = '0;

   // Active-high segment codes for hex digits 0..F (bit 0 = segment a).
   localparam logic [7:0] SEG_CODE [16] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
      8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
   };

   function automatic logic [7:0] seg_of_nibble(input logic [3:0] nib);
      return SEG_CODE[nib];
   endfunction

endpackage

// File: rtl/seg7_frame_scheduler_if.sv
// Frame stream from the scheduler to the serial shift/scan engine.
// A frame moves when out_valid and out_ready are both high at a clock edge.
interface seg7_frame_scheduler_if;
   import seg7_pkg::*;

   logic [FRAME_W-1:0] out_frame;
   logic               out_valid;
   logic               out_ready;

   modport master (output out_frame, output out_valid, input out_ready);
   modport slave  (input out_frame, input out_valid, output out_ready);

endinterface

// File: rtl/seg7_frame_scheduler_cycle_timer.sv
// Loadable down-counter: load wins over counting, counting sticks at zero,
// and expire flags the cycle whose clock edge takes the count from 1 to 0.
module seg7_cycle_timer #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic             idle,
   output logic             expire
);

   logic [CNT_W-1:0] count;

   // Count register: reload, else decrement while enabled and non-zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign idle   = (count == '0);
   assign expire = en && (count == CNT_W'(1));

endmodule

// File: rtl/seg7_frame_scheduler.sv
// Chooses which of spectrum / message / alarm owns the display, times the
// message overlay and alarm blink, and offers whole frames downstream.
// Frames are offered "latest wins": events while an offer is pending only
// mark dirty, and the newest visible frame goes out after acceptance.
module seg7_frame_scheduler
   import seg7_pkg::*;
#(
   parameter int unsigned MSG_HOLD    = 24_000_000,
   parameter int unsigned MIN_DWELL   = 6_000_000,
   parameter int unsigned BLINK_CYC   = 6_000_000,
   parameter int unsigned REFRESH_CYC = 1_200_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [FRAME_W-1:0]     spec_frame,
   input  logic                   spec_valid,
   input  logic                   msg_req,
   input  logic [FRAME_W-1:0]     msg_frame,
   output logic                   msg_ack,
   input  logic                   alarm_req,
   input  logic [FRAME_W-1:0]     alarm_frame,
   output logic                   alarm_ack,
   seg7_frame_scheduler_if.master out_if,
   output logic [1:0]             active_src
);

   sched_state_t       state, state_nxt;
   logic               msg_take;
   logic               alarm_enter;
   logic [FRAME_W-1:0] spec_buf;
   logic [FRAME_W-1:0] msg_buf;
   logic [FRAME_W-1:0] alarm_last;
   logic [FRAME_W-1:0] visible;
   logic               blink_on;
   logic               dirty;
   logic               dirty_set;
   logic               push;
   logic               accept;
   logic               alarm_chg;

   logic hold_idle, hold_exp;
   logic dwell_idle, dwell_exp;
   logic blink_idle, blink_exp;
   logic refresh_idle, refresh_exp;
   logic timers_unused;

   // Hold and dwell only run while the message is on screen, so an alarm
   // freezes them and the overlay resumes with its remaining time.
   seg7_cycle_timer #(.CNT_W(32)) u_hold (
      .clk(clk), .rst_n(rst_n), .load(msg_take), .load_val(MSG_HOLD),
      .en(state == ST_MSG), .idle(hold_idle), .expire(hold_exp)
   );

   seg7_cycle_timer #(.CNT_W(32)) u_dwell (
      .clk(clk), .rst_n(rst_n), .load(msg_take), .load_val(MIN_DWELL),
      .en(state == ST_MSG), .idle(dwell_idle), .expire(dwell_exp)
   );

   // Blink timer restarts on alarm entry and on each toggle.
   seg7_cycle_timer #(.CNT_W(32)) u_blink (
      .clk(clk), .rst_n(rst_n), .load(alarm_enter | blink_exp), .load_val(BLINK_CYC),
      .en(state == ST_ALARM), .idle(blink_idle), .expire(blink_exp)
   );

   // Refresh restarts on every acceptance; a zero period never expires.
   seg7_cycle_timer #(.CNT_W(32)) u_refresh (
      .clk(clk), .rst_n(rst_n), .load(accept), .load_val(REFRESH_CYC),
      .en(1'b1), .idle(refresh_idle), .expire(refresh_exp)
   );

   assign timers_unused = dwell_exp ^ blink_idle ^ refresh_idle;

   // Source arbitration: alarm beats everything; a message is taken from
   // SPEC, or replaces the current one once its dwell has run out.
   always_comb begin
      state_nxt = state;
      msg_take  = 1'b0;
      unique case (state)
         ST_SPEC: begin
            if (alarm_req) begin
               state_nxt = ST_ALARM;
            end else if (msg_req && !msg_ack) begin
               state_nxt = ST_MSG;
               msg_take  = 1'b1;
            end
         end
         ST_MSG: begin
            if (alarm_req) begin
               state_nxt = ST_ALARM;
            end else if (msg_req && !msg_ack && dwell_idle) begin
               msg_take = 1'b1;
            end else if (hold_exp) begin
               state_nxt = ST_SPEC;
            end
         end
         ST_ALARM: begin
            if (!alarm_req) begin
               state_nxt = hold_idle ? ST_SPEC : ST_MSG;
            end
         end
         default: state_nxt = ST_SPEC;
      endcase
   end

   assign alarm_enter = (state != ST_ALARM) && (state_nxt == ST_ALARM);

   // State register with its registered mirrors and handshake pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_SPEC;
         active_src <= SRC_SPEC;
         msg_ack    <= 1'b0;
         alarm_ack  <= 1'b0;
      end else begin
         state      <= state_nxt;
         active_src <= state_nxt;
         msg_ack    <= msg_take;
         alarm_ack  <= alarm_enter;
      end
   end

   // Spectrum buffer follows spec_valid in every state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         spec_buf <= '0;
      end else if (spec_valid) begin
         spec_buf <= spec_frame;
      end
   end

   // Message buffer is kept across an alarm so the overlay can resume.
   always_ff @(posedge clk) begin
      if (msg_take) begin
         msg_buf <= msg_frame;
      end
   end

   // Blink phase starts ON at alarm entry and flips on each timer expiry.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         blink_on <= 1'b1;
      end else if (alarm_enter) begin
         blink_on <= 1'b1;
      end else if (blink_exp) begin
         blink_on <= ~blink_on;
      end
   end

   // Previous alarm_frame sample, to notice content changes while shown.
   always_ff @(posedge clk) begin
      alarm_last <= alarm_frame;
   end

   assign alarm_chg = (state == ST_ALARM) && blink_on && (alarm_frame != alarm_last);

   // Frame the current source would put on the display right now.
   always_comb begin
      visible = spec_buf;
      unique case (state)
         ST_SPEC:  visible = spec_buf;
         ST_MSG:   visible = msg_buf;
         ST_ALARM: visible = blink_on ? alarm_frame : FRAME_BLANK;
         default:  visible = spec_buf;
      endcase
   end

   assign accept    = out_if.out_valid && out_if.out_ready;
   assign push      = !out_if.out_valid && dirty;
   assign dirty_set = (state_nxt != state) | msg_take | blink_exp | alarm_chg |
                      (spec_valid && (state == ST_SPEC)) | refresh_exp;

   // Offer register: an event coinciding with a push stays dirty, since
   // the pushed frame predates it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_if.out_valid <= 1'b0;
         out_if.out_frame <= '0;
         dirty            <= 1'b1;
      end else begin
         dirty <= dirty_set | (dirty & ~push);
         if (push) begin
            out_if.out_valid <= 1'b1;
            out_if.out_frame <= visible;
         end else if (accept) begin
            out_if.out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_frame_scheduler.sv
// Bench for seg7_frame_scheduler with short timers (hold 20, dwell 5,
// blink 4, refresh off). Offered frames are checked against a queue of
// expected frames; timing and control outputs are checked inline.
module tb_seg7_frame_scheduler;
   import seg7_pkg::*;

   localparam logic [63:0] F1  = 64'h3F06_5B4F_666D_7D07;
   localparam logic [63:0] MA  = 64'h0000_0000_0000_7777;
   localparam logic [63:0] MB  = 64'h0000_0000_5E79_3977;
   localparam logic [63:0] MC  = 64'h0000_0000_0000_7C7C;
   localparam logic [63:0] MD  = 64'h0000_0000_0071_7171;
   localparam logic [63:0] AF  = 64'h7777_7777_7777_7777;
   localparam logic [63:0] AF2 = 64'h7979_7979_7979_7979;
   localparam logic [63:0] G1  = 64'h0606_0606_0606_0606;
   localparam logic [63:0] G2  = 64'h5B5B_5B5B_5B5B_5B5B;
   localparam logic [63:0] G3  = 64'h4F4F_4F4F_4F4F_4F4F;
   localparam logic [63:0] G4  = 64'h6666_6666_6666_6666;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] spec_frame;
   logic        spec_valid;
   logic        msg_req;
   logic [63:0] msg_frame;
   logic        msg_ack;
   logic        alarm_req;
   logic [63:0] alarm_frame;
   logic        alarm_ack;
   logic [1:0]  active_src;

   int n_checks = 0;
   int n_pass   = 0;
   logic [63:0] exp_q[$];

   seg7_frame_scheduler_if bus();

   seg7_frame_scheduler #(
      .MSG_HOLD(20), .MIN_DWELL(5), .BLINK_CYC(4), .REFRESH_CYC(0)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .spec_frame(spec_frame), .spec_valid(spec_valid),
      .msg_req(msg_req), .msg_frame(msg_frame), .msg_ack(msg_ack),
      .alarm_req(alarm_req), .alarm_frame(alarm_frame), .alarm_ack(alarm_ack),
      .out_if(bus), .active_src(active_src)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted frame must match the oldest expectation.
   initial begin
      logic [63:0] exp_frame;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL offer_unexpected: got frame %h, required no offer", bus.out_frame);
            end else begin
               exp_frame = exp_q.pop_front();
               if (bus.out_frame !== exp_frame)
                  $display("FAIL offer_frame: got %h, required %h", bus.out_frame, exp_frame);
               else
                  n_pass++;
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required run to complete");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int extra;
      rst_n = 1'b0; spec_valid = 1'b0; spec_frame = '0; msg_req = 1'b0; msg_frame = '0;
      alarm_req = 1'b0; alarm_frame = '0; bus.out_ready = 1'b1;
      repeat (2) tick();
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_frame !== 64'h0) $display("FAIL rst_out_frame: got %h, required 0", bus.out_frame); else n_pass++;
      n_checks++; if (msg_ack !== 1'b0) $display("FAIL rst_msg_ack: got %b, required 0", msg_ack); else n_pass++;
      n_checks++; if (alarm_ack !== 1'b0) $display("FAIL rst_alarm_ack: got %b, required 0", alarm_ack); else n_pass++;
      n_checks++; if (active_src !== SRC_SPEC) $display("FAIL rst_active_src: got %0d, required 0", active_src); else n_pass++;
      exp_q.push_back(64'h0);
      rst_n = 1'b1;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== 64'h0)
         $display("FAIL rst_first_offer: got valid %b frame %h, required valid 1 frame 0", bus.out_valid, bus.out_frame);
      else n_pass++;
      tick();
      extra = 0;
      repeat (6) begin tick(); if (bus.out_valid === 1'b1) extra++; end
      n_checks++; if (extra != 0) $display("FAIL rst_single_offer: got %0d extra offer cycles, required 0", extra); else n_pass++;
   endtask

   task automatic test_spec();
      spec_frame = F1; spec_valid = 1'b1;
      exp_q.push_back(F1);
      tick();
      spec_valid = 1'b0;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL spec_latency_early: got valid %b, required 0", bus.out_valid); else n_pass++;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== F1)
         $display("FAIL spec_offer: got valid %b frame %h, required valid 1 frame %h", bus.out_valid, bus.out_frame, F1);
      else n_pass++;
      repeat (2) tick();
      n_checks++; if (exp_q.size() != 0) $display("FAIL spec_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_msg();
      int n;
      msg_frame = MA; msg_req = 1'b1;
      exp_q.push_back(MA);
      tick();
      n_checks++; if (msg_ack !== 1'b1) $display("FAIL msg_ack: got %b, required 1", msg_ack); else n_pass++;
      n_checks++; if (active_src !== SRC_MSG) $display("FAIL msg_src: got %0d, required 1", active_src); else n_pass++;
      msg_req = 1'b0;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== MA)
         $display("FAIL msg_offer: got valid %b frame %h, required valid 1 frame %h", bus.out_valid, bus.out_frame, MA);
      else n_pass++;
      n_checks++; if (msg_ack !== 1'b0) $display("FAIL msg_ack_pulse: got %b, required 0", msg_ack); else n_pass++;
      exp_q.push_back(F1);
      repeat (18) tick();
      n_checks++; if (active_src !== SRC_MSG) $display("FAIL msg_hold_19: got %0d, required 1", active_src); else n_pass++;
      tick();
      n_checks++; if (active_src !== SRC_SPEC) $display("FAIL msg_hold_20: got %0d, required 0", active_src); else n_pass++;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== F1)
         $display("FAIL msg_back_to_spec: got valid %b frame %h, required valid 1 frame %h", bus.out_valid, bus.out_frame, F1);
      else n_pass++;
      tick();
      // Second request arrives while the first message is still in dwell.
      msg_frame = MA; msg_req = 1'b1;
      exp_q.push_back(MA);
      tick();
      msg_req = 1'b0;
      repeat (2) tick();
      msg_frame = MB; msg_req = 1'b1;
      exp_q.push_back(MB);
      n = 0;
      while (n < 30 && msg_ack !== 1'b1) begin tick(); n++; end
      n_checks++; if (n != 4) $display("FAIL msg_dwell_ack: got ack after %0d cycles, required 4", n); else n_pass++;
      msg_req = 1'b0;
      exp_q.push_back(F1);
      n = 0;
      while (n < 40 && active_src !== SRC_SPEC) begin tick(); n++; end
      n_checks++; if (n != 20) $display("FAIL msg_replace_hold: got %0d cycles, required 20", n); else n_pass++;
      repeat (3) tick();
      n_checks++; if (exp_q.size() != 0) $display("FAIL msg_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_alarm();
      int n;
      int bad;
      logic exp_v;
      msg_frame = MC; msg_req = 1'b1;
      exp_q.push_back(MC);
      tick();
      msg_req = 1'b0;
      repeat (7) tick();
      alarm_frame = AF; alarm_req = 1'b1;
      exp_q.push_back(AF); exp_q.push_back(64'h0); exp_q.push_back(AF);
      tick();
      n_checks++; if (active_src !== SRC_ALARM) $display("FAIL alarm_src: got %0d, required 2", active_src); else n_pass++;
      n_checks++; if (alarm_ack !== 1'b1) $display("FAIL alarm_ack: got %b, required 1", alarm_ack); else n_pass++;
      bad = 0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         exp_v = (k == 1 || k == 5 || k == 9);
         if (bus.out_valid !== exp_v) begin
            bad++;
            $display("FAIL alarm_blink_cycle%0d: got valid %b, required %b", k, bus.out_valid, exp_v);
         end
      end
      n_checks++; if (bad != 0) $display("FAIL alarm_blink_timing: got %0d wrong cycles, required 0", bad); else n_pass++;
      n_checks++; if (alarm_ack !== 1'b0) $display("FAIL alarm_ack_pulse: got %b, required 0", alarm_ack); else n_pass++;
      alarm_req = 1'b0;
      exp_q.push_back(MC);
      tick();
      n_checks++; if (active_src !== SRC_MSG) $display("FAIL alarm_resume_msg: got %0d, required 1", active_src); else n_pass++;
      exp_q.push_back(F1);
      n = 0;
      while (n < 40 && active_src !== SRC_SPEC) begin tick(); n++; end
      n_checks++; if (n != 12) $display("FAIL alarm_frozen_hold: got %0d cycles, required 12", n); else n_pass++;
      repeat (3) tick();
      n_checks++; if (exp_q.size() != 0) $display("FAIL alarm_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_simultaneous();
      int n;
      int acks;
      msg_frame = MD; msg_req = 1'b1; alarm_frame = AF2; alarm_req = 1'b1;
      exp_q.push_back(AF2);
      tick();
      n_checks++; if (active_src !== SRC_ALARM) $display("FAIL simul_src: got %0d, required 2", active_src); else n_pass++;
      n_checks++; if (alarm_ack !== 1'b1) $display("FAIL simul_alarm_ack: got %b, required 1", alarm_ack); else n_pass++;
      acks = (msg_ack === 1'b1) ? 1 : 0;
      repeat (2) begin tick(); if (msg_ack === 1'b1) acks++; end
      n_checks++; if (acks != 0) $display("FAIL simul_no_msg_ack: got %0d acks, required 0", acks); else n_pass++;
      alarm_req = 1'b0;
      exp_q.push_back(F1); exp_q.push_back(MD);
      tick();
      n_checks++; if (active_src !== SRC_SPEC || msg_ack !== 1'b0)
         $display("FAIL simul_exit: got src %0d ack %b, required src 0 ack 0", active_src, msg_ack);
      else n_pass++;
      tick();
      n_checks++; if (msg_ack !== 1'b1 || active_src !== SRC_MSG)
         $display("FAIL simul_late_ack: got ack %b src %0d, required ack 1 src 1", msg_ack, active_src);
      else n_pass++;
      msg_req = 1'b0;
      exp_q.push_back(F1);
      n = 0;
      while (n < 40 && active_src !== SRC_SPEC) begin tick(); n++; end
      n_checks++; if (n != 20) $display("FAIL simul_hold: got %0d cycles, required 20", n); else n_pass++;
      repeat (3) tick();
      n_checks++; if (exp_q.size() != 0) $display("FAIL simul_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int extra;
      bus.out_ready = 1'b0;
      spec_frame = G1; spec_valid = 1'b1;
      tick();
      spec_frame = G2;
      tick();
      spec_frame = G3;
      tick();
      spec_valid = 1'b0;
      repeat (3) tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== G1)
         $display("FAIL bp_stall: got valid %b frame %h, required valid 1 frame %h", bus.out_valid, bus.out_frame, G1);
      else n_pass++;
      exp_q.push_back(G1); exp_q.push_back(G3);
      bus.out_ready = 1'b1;
      tick();
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_gap: got valid %b, required 0", bus.out_valid); else n_pass++;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1 || bus.out_frame !== G3)
         $display("FAIL bp_latest: got valid %b frame %h, required valid 1 frame %h", bus.out_valid, bus.out_frame, G3);
      else n_pass++;
      tick();
      extra = 0;
      repeat (5) begin tick(); if (bus.out_valid === 1'b1) extra++; end
      n_checks++; if (extra != 0) $display("FAIL bp_single: got %0d extra offer cycles, required 0", extra); else n_pass++;
      n_checks++; if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d pending, required 0", exp_q.size()); else n_pass++;
      // Reset while an offer is stalled drops it without a handshake.
      bus.out_ready = 1'b0;
      spec_frame = G4; spec_valid = 1'b1;
      tick();
      spec_valid = 1'b0;
      tick();
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_pending: got valid %b, required 1", bus.out_valid); else n_pass++;
      rst_n = 1'b0;
      tick();
      n_checks++; if (bus.out_valid !== 1'b0 || bus.out_frame !== 64'h0)
         $display("FAIL bp_reset_drop: got valid %b frame %h, required valid 0 frame 0", bus.out_valid, bus.out_frame);
      else n_pass++;
      n_checks++; if (active_src !== SRC_SPEC) $display("FAIL bp_reset_src: got %0d, required 0", active_src); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_spec();
      test_msg();
      test_alarm();
      test_simultaneous();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
